// File: rtl/text_console_gen_if.sv
// Write/clear port of text_console_gen: valid/ready character writes, clear request,
// busy flag and the cursor position reported back to the writer.
interface text_console_gen_if #(
  parameter int CX_W = 7,
  parameter int CY_W = 5
);
  logic            wr_valid;
  logic            wr_ready;
  logic [6:0]      wr_char;
  logic [2:0]      wr_fg;
  logic [2:0]      wr_bg;
  logic            clr_req;
  logic            busy;
  logic [CX_W-1:0] cur_x;
  logic [CY_W-1:0] cur_y;

  modport slave  (input  wr_valid, wr_char, wr_fg, wr_bg, clr_req,
                  output wr_ready, busy, cur_x, cur_y);
  modport master (output wr_valid, wr_char, wr_fg, wr_bg, clr_req,
                  input  wr_ready, busy, cur_x, cur_y);
endinterface

// File: rtl/text_console_gen.sv
// Character console renderer: tile RAM, cursor-advancing write port, hardware clear, reverse-video cursor.
// Define CURSOR_BLINK_EN to build the cursor blink counter; otherwise the cursor is always drawn.
module text_console_gen #(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 30,
  parameter int         CX_W      = 7,
  parameter int         CY_W      = 5,
  parameter logic [6:0] CLR_CHAR  = 7'h20,
  parameter int         BLINK_DIV = 25_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  text_console_gen_if.slave wr_if,
  input  logic              video_on,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  output logic [10:0]       font_addr,
  input  logic [7:0]        font_data,
  output logic [2:0]        rgb
);
  localparam int AW = CX_W + CY_W;
  localparam logic [CX_W-1:0] LAST_X = CX_W'(COLS - 1);
  localparam logic [CY_W-1:0] LAST_Y = CY_W'(ROWS - 1);
  localparam logic [10:0] X_LIM = 11'(COLS * 8);
  localparam logic [10:0] Y_LIM = 11'(ROWS * 16);

  if (COLS > (1 << CX_W) || ROWS > (1 << CY_W) || BLINK_DIV < 1) begin : g_bad_param
    $error("text_console_gen: COLS/ROWS exceed cursor width or BLINK_DIV < 1");
  end

  typedef enum logic {IDLE, CLEAR} state_e;
  state_e state_q, state_d;
  logic [CX_W-1:0] cur_x_q, cur_x_d, clr_x_q, clr_x_d;
  logic [CY_W-1:0] cur_y_q, cur_y_d, clr_y_q, clr_y_d;
  logic            ram_we, wr_fire, cur_vis;
  logic [AW-1:0]   ram_waddr;
  logic [12:0]     ram_wdata;
  logic [12:0]     ram [2**AW];

  assign wr_if.wr_ready = (state_q == IDLE) && !wr_if.clr_req;
  assign wr_if.busy     = (state_q == CLEAR);
  assign wr_if.cur_x    = cur_x_q;
  assign wr_if.cur_y    = cur_y_q;
  assign wr_fire        = wr_if.wr_valid && wr_if.wr_ready;

  always_comb begin
    state_d   = state_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    clr_x_d   = clr_x_q;
    clr_y_d   = clr_y_q;
    ram_we    = 1'b0;
    ram_waddr = {cur_y_q, cur_x_q};
    ram_wdata = {wr_if.wr_char, wr_if.wr_fg, wr_if.wr_bg};
    case (state_q)
      IDLE: begin
        if (wr_if.clr_req) begin
          state_d = CLEAR;
          clr_x_d = '0;
          clr_y_d = '0;
        end else if (wr_fire) begin
          ram_we = (wr_if.wr_char != 7'h0A);
          // newline and end-of-line both start the next row
          if (wr_if.wr_char == 7'h0A || cur_x_q == LAST_X) begin
            cur_x_d = '0;
            cur_y_d = (cur_y_q == LAST_Y) ? '0 : cur_y_q + 1'b1;
          end else begin
            cur_x_d = cur_x_q + 1'b1;
          end
        end
      end
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = {clr_y_q, clr_x_q};
        ram_wdata = {CLR_CHAR, 3'b010, 3'b000};
        if (clr_x_q == LAST_X) begin
          clr_x_d = '0;
          if (clr_y_q == LAST_Y) begin
            state_d = IDLE;
            cur_x_d = '0;
            cur_y_d = '0;
          end else begin
            clr_y_d = clr_y_q + 1'b1;
          end
        end else begin
          clr_x_d = clr_x_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_vis_q, blink_vis_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_vis_d = blink_vis_q;
    // typing keeps the cursor solid; the blink restarts from the visible phase
    if (wr_fire) begin
      blink_cnt_d = '0;
      blink_vis_d = 1'b1;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_vis_d = !blink_vis_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      blink_vis_q <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_vis_q <= blink_vis_d;
    end
  end
  assign cur_vis = blink_vis_q;
`else
  assign cur_vis = 1'b1;
`endif

  // render pipeline: stage 1 = RAM word + pixel info, stage 2 = font_data valid
  logic [12:0]     s1_word_q;
  logic [CX_W-1:0] s1_col_q, s2_col_q;
  logic [CY_W-1:0] s1_row_q, s2_row_q;
  logic [3:0]      s1_yr_q;
  logic [2:0]      s1_xb_q, s2_xb_q, s2_fg_q, s2_bg_q;
  logic            s1_in_q, s1_von_q, s2_in_q, s2_von_q;

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      clr_x_q   <= '0;
      clr_y_q   <= '0;
      s1_word_q <= '0;
      s1_col_q  <= '0;
      s1_row_q  <= '0;
      s1_yr_q   <= '0;
      s1_xb_q   <= '0;
      s1_in_q   <= 1'b0;
      s1_von_q  <= 1'b0;
      s2_col_q  <= '0;
      s2_row_q  <= '0;
      s2_xb_q   <= '0;
      s2_fg_q   <= '0;
      s2_bg_q   <= '0;
      s2_in_q   <= 1'b0;
      s2_von_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      clr_x_q   <= clr_x_d;
      clr_y_q   <= clr_y_d;
      s1_word_q <= ram[{pixel_y[3+CY_W:4], pixel_x[2+CX_W:3]}];
      s1_col_q  <= pixel_x[2+CX_W:3];
      s1_row_q  <= pixel_y[3+CY_W:4];
      s1_yr_q   <= pixel_y[3:0];
      s1_xb_q   <= pixel_x[2:0];
      s1_in_q   <= ({1'b0, pixel_x} < X_LIM) && ({1'b0, pixel_y} < Y_LIM);
      s1_von_q  <= video_on;
      s2_col_q  <= s1_col_q;
      s2_row_q  <= s1_row_q;
      s2_xb_q   <= s1_xb_q;
      s2_fg_q   <= s1_word_q[5:3];
      s2_bg_q   <= s1_word_q[2:0];
      s2_in_q   <= s1_in_q;
      s2_von_q  <= s1_von_q;
    end
  end

  assign font_addr = {s1_word_q[12:6], s1_yr_q};

  logic       cur_hit;
  logic [2:0] fg_eff, bg_eff;
  always_comb begin
    cur_hit = cur_vis && (s2_col_q == cur_x_q) && (s2_row_q == cur_y_q);
    fg_eff  = cur_hit ? s2_bg_q : s2_fg_q;
    bg_eff  = cur_hit ? s2_fg_q : s2_bg_q;
    rgb     = 3'b000;
    if (s2_von_q && s2_in_q) rgb = font_data[~s2_xb_q] ? fg_eff : bg_eff;
  end
endmodule

// File: tb/tb_text_console_gen.sv
// Randomised self-checking bench for text_console_gen against a tile-array reference model.
module tb_text_console_gen;
  localparam int COLS = 40, ROWS = 6, CX_W = 7, CY_W = 5, BLINK_DIV = 4;

  logic       clk = 1'b0, reset_n = 1'b0, video_on = 1'b0;
  logic [9:0] pixel_x = '0, pixel_y = '0;
  logic [10:0] font_addr;
  logic [7:0] font_data = '0;
  logic [2:0] rgb;

  text_console_gen_if #(.CX_W(CX_W), .CY_W(CY_W)) wif();

  text_console_gen #(.COLS(COLS), .ROWS(ROWS), .CX_W(CX_W), .CY_W(CY_W),
                     .CLR_CHAR(7'h20), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .wr_if(wif), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .font_addr(font_addr),
    .font_data(font_data), .rgb(rgb));

  always #5 clk = ~clk;

  function automatic logic [7:0] font_fn(input logic [10:0] a);
    logic [10:0] t;
    t = (a * 11'd173) ^ (a >> 3) ^ 11'h2A5;
    return t[7:0] ^ t[10:3];
  endfunction

  always @(posedge clk) font_data <= font_fn(font_addr);

  int passed = 0, total = 0;
  logic [12:0] m_ram [ROWS][COLS];
  int m_cx = 0, m_cy = 0;
  int bk;

  // clock edges since reset or the last accepted write
  always @(posedge clk or negedge reset_n)
    if (!reset_n) bk <= 0;
    else if (wif.wr_valid && wif.wr_ready) bk <= 0;
    else bk <= bk + 1;

  function automatic bit cursor_vis();
`ifdef CURSOR_BLINK_EN
    return ((bk / BLINK_DIV) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [2:0] exp_rgb(input int x, input int y, input bit von);
    int col = x / 8;
    int row = y / 16;
    logic [12:0] w;
    logic [7:0]  f;
    logic [2:0]  fg, bg, t;
    if (!von || col >= COLS || row >= ROWS) return 3'b000;
    w  = m_ram[row][col];
    f  = font_fn({w[12:6], 4'(y % 16)});
    fg = w[5:3];
    bg = w[2:0];
    if (col == m_cx && row == m_cy && cursor_vis()) begin t = fg; fg = bg; bg = t; end
    return f[7 - (x % 8)] ? fg : bg;
  endfunction

  typedef struct { int x; int y; bit von; } pix_t;
  pix_t pq[$];

  // entered and left on a negedge; rgb at each negedge reflects the pixel driven two negedges earlier
  task automatic render_sweep(input string name, input int n, input int x0, input int w,
                              input int y0, input int h, input bit rnd, input int von_mode);
    pix_t p, e;
    logic [2:0] ex;
    pq.delete();
    for (int i = 0; i < n + 2; i++) begin
      if (i >= 2) begin
        e  = pq.pop_front();
        ex = exp_rgb(e.x, e.y, e.von);
        total++;
        if (rgb !== ex) $display("FAIL %s: pixel (%0d,%0d) von=%0d rgb=%b expected %b",
                                 name, e.x, e.y, e.von, rgb, ex);
        else passed++;
      end
      if (i < n) begin
        p.x   = rnd ? x0 + int'($urandom_range(w - 1)) : x0 + i % w;
        p.y   = rnd ? y0 + int'($urandom_range(h - 1)) : y0 + (i / w) % h;
        p.von = (von_mode == 0) ? 1'b1 : (von_mode == 1) ? ($urandom_range(3) != 0) : 1'b0;
        pixel_x  = 10'(p.x);
        pixel_y  = 10'(p.y);
        video_on = p.von;
        pq.push_back(p);
      end
      @(negedge clk);
    end
    video_on = 1'b0;
  endtask

  task automatic check_cursor(input string name);
    total++;
    if (wif.cur_x !== CX_W'(m_cx) || wif.cur_y !== CY_W'(m_cy))
      $display("FAIL %s: cursor (%0d,%0d) expected (%0d,%0d)", name, wif.cur_x, wif.cur_y, m_cx, m_cy);
    else passed++;
  endtask

  task automatic write_char(input logic [6:0] ch, input logic [2:0] fg, input logic [2:0] bg);
    wif.wr_valid = 1'b1;
    wif.wr_char  = ch;
    wif.wr_fg    = fg;
    wif.wr_bg    = bg;
    total++;
    if (wif.wr_ready !== 1'b1) $display("FAIL write_ready: wr_ready=%b expected 1", wif.wr_ready);
    else passed++;
    if (ch != 7'h0A) begin
      m_ram[m_cy][m_cx] = {ch, fg, bg};
      m_cx = (m_cx + 1) % COLS;
      if (m_cx == 0) m_cy = (m_cy + 1) % ROWS;
    end else begin
      m_cx = 0;
      m_cy = (m_cy + 1) % ROWS;
    end
    @(negedge clk);
    wif.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    wif.wr_valid = 1'b0; wif.clr_req = 1'b0;
    wif.wr_char = '0; wif.wr_fg = '0; wif.wr_bg = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total += 5;
    if (wif.cur_x !== '0 || wif.cur_y !== '0) $display("FAIL reset_cursor: (%0d,%0d) expected (0,0)", wif.cur_x, wif.cur_y); else passed++;
    if (wif.busy !== 1'b0) $display("FAIL reset_busy: %b expected 0", wif.busy); else passed++;
    if (wif.wr_ready !== 1'b1) $display("FAIL reset_ready: %b expected 1", wif.wr_ready); else passed++;
    if (font_addr !== '0) $display("FAIL reset_font_addr: %h expected 0", font_addr); else passed++;
    if (rgb !== 3'b000) $display("FAIL reset_rgb: %b expected 000", rgb); else passed++;
    wif.clr_req = 1'b1;
    #1;
    total++;
    if (wif.wr_ready !== 1'b0) $display("FAIL reset_ready_clr: %b expected 0", wif.wr_ready); else passed++;
    wif.clr_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_cx = 0; m_cy = 0;
  endtask

  task automatic test_clear();
    int cnt = 0;
    write_char(7'h48, 3'b111, 3'b001);
    write_char(7'h69, 3'b111, 3'b001);
    check_cursor("pre_clear_cursor");
    wif.clr_req = 1'b1; wif.wr_valid = 1'b1; wif.wr_char = 7'h5A;
    #1;
    total++;
    if (wif.wr_ready !== 1'b0) $display("FAIL clr_priority: wr_ready=%b expected 0", wif.wr_ready); else passed++;
    @(negedge clk);
    wif.clr_req = 1'b0;
    while (wif.busy === 1'b1 && cnt < ROWS * COLS + 20) begin
      cnt++;
      @(negedge clk);
    end
    wif.wr_valid = 1'b0;
    total++;
    if (cnt != ROWS * COLS) $display("FAIL clear_busy_len: %0d cycles expected %0d", cnt, ROWS * COLS); else passed++;
    foreach (m_ram[r, c]) m_ram[r][c] = {7'h20, 3'b010, 3'b000};
    m_cx = 0; m_cy = 0;
    check_cursor("clear_cursor");
    for (int r = 0; r < ROWS; r++)
      render_sweep("clear_tiles", COLS * 8, 0, COLS * 8, r * 16 + int'($urandom_range(15)), 1, 0, 0);
  endtask

  task automatic test_write_glyph();
    write_char(7'h41, 3'b010, 3'b000);
    check_cursor("glyph_cursor");
    render_sweep("glyph_tiles", 256, 0, 16, 0, 16, 0, 0);
  endtask

  task automatic test_blink();
    write_char(7'h42, 3'b110, 3'b001);
    render_sweep("blink_a", 20, m_cx * 8 + 3, 1, m_cy * 16 + 5, 1, 0, 0);
    write_char(7'h43, 3'b101, 3'b011);
    render_sweep("blink_b", 6, m_cx * 8 + 6, 1, m_cy * 16 + 9, 1, 0, 0);
    write_char(7'h44, 3'b011, 3'b100);
    render_sweep("blink_c", 20, m_cx * 8 + 1, 1, m_cy * 16 + 2, 1, 0, 0);
  endtask

  task automatic test_wrap();
    while (m_cy != ROWS - 1) write_char(7'h0A, 3'b000, 3'b000);
    while (m_cx != COLS - 1) write_char(7'($urandom_range(126, 32)), 3'($urandom), 3'($urandom));
    check_cursor("wrap_last_tile");
    write_char(7'h7E, 3'b100, 3'b011);
    check_cursor("wrap_to_origin");
  endtask

  task automatic test_newline();
    repeat (3) write_char(7'h0A, 3'b000, 3'b000);
    repeat (5) write_char(7'($urandom_range(126, 32)), 3'($urandom), 3'($urandom));
    check_cursor("newline_at_5_3");
    write_char(7'h0A, 3'b111, 3'b111);
    check_cursor("newline_cursor");
    render_sweep("newline_ram", 128, 5 * 8, 8, 3 * 16, 16, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ch;
    for (int i = 0; i < 60; i++) begin
      ch = ($urandom_range(9) == 0) ? 7'h0A : 7'($urandom_range(126, 32));
      write_char(ch, 3'($urandom), 3'($urandom));
      check_cursor("rand_cursor");
    end
    render_sweep("rand_inrange", 300, 0, COLS * 8, 0, ROWS * 16, 1, 1);
    render_sweep("rand_fullscreen", 300, 0, 640, 0, 480, 1, 1);
    render_sweep("line_sweep", 640, 0, 640, int'($urandom_range(ROWS * 16 - 1)), 1, 0, 0);
    render_sweep("video_off", 50, 0, COLS * 8, 0, ROWS * 16, 1, 2);
  endtask

  task automatic test_reset_mid_clear();
    wif.clr_req = 1'b1;
    @(negedge clk);
    wif.clr_req = 1'b0;
    repeat (37) @(negedge clk);
    total++;
    if (wif.busy !== 1'b1) $display("FAIL midclr_busy: %b expected 1", wif.busy); else passed++;
    #2 reset_n = 1'b0;
    #1;
    total += 3;
    if (wif.busy !== 1'b0) $display("FAIL midclr_reset_busy: %b expected 0", wif.busy); else passed++;
    if (wif.cur_x !== '0 || wif.cur_y !== '0) $display("FAIL midclr_reset_cursor: (%0d,%0d) expected (0,0)", wif.cur_x, wif.cur_y); else passed++;
    if (rgb !== 3'b000) $display("FAIL midclr_reset_rgb: %b expected 000", rgb); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    m_cx = 0; m_cy = 0;
    write_char(7'h51, 3'b001, 3'b110);
    check_cursor("post_reset_write");
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clear();
    test_write_glyph();
    test_blink();
    test_wrap();
    test_newline();
    test_back_to_back();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/text_console_gen.md
# text_console_gen

Parametrised character-console renderer for the VGA text path. It sits between the VGA sync generator (pixel_x, pixel_y, video_on) and the RGB output pins. It owns an internal tile RAM that stores a character plus foreground/background colour per tile. A valid/ready write port auto-advances the cursor, handles newline and runs a hardware clear-screen sequence, and the block draws a reverse-video cursor that can optionally blink.

## Interface
Parameters:
- COLS, 80, visible tile columns (8 px wide each)
- ROWS, 30, visible tile rows (16 px tall each)
- CX_W, 7, cursor column width; 2^CX_W ≥ COLS
- CY_W, 5, cursor row width; 2^CY_W ≥ ROWS
- CLR_CHAR, 7'h20, character written by a clear
- BLINK_DIV, 25_000_000, clk cycles per cursor blink half-period

Ports:
- clk  in  1  system/pixel clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- video_on  in  1  display-active from sync generator
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_char  in  7  ASCII code (7'h0A = newline)
- wr_fg  in  3  foreground RGB for this character
- wr_bg  in  3  background RGB for this character
- clr_req  in  1  clear-screen request, sampled in IDLE
- busy  out  1  clear sequence in progress
- cur_x  out  CX_W  cursor column
- cur_y  out  CY_W  cursor row
- font_addr  out  11  {char, row[3:0]} to external font ROM
- font_data  in  8  ROM word, valid one cycle after font_addr; bit 7 = leftmost pixel
- rgb  out  3  pixel colour

## Operation
- Tile RAM: depth 2^(CX_W+CY_W), address {row, col}, 13-bit word {char, fg, bg}. It has one write port and one registered read port. Contents are not reset.
- Control FSM states: IDLE, CLEAR. Reset → IDLE.
- wr_ready = (state==IDLE) && !clr_req. clr_req has priority over a simultaneous write.
- IDLE, accepted write with char ≠ 7'h0A:
  - Write {wr_char, wr_fg, wr_bg} at (cur_y, cur_x).
  - Advance the cursor. If cur_x == COLS-1, set cur_x = 0 and advance the row. A row advance from ROWS-1 wraps to 0.
- IDLE, accepted 7'h0A: no RAM write. Set cur_x = 0 and advance the row with the same wrap.
- IDLE with clr_req = 1: go to CLEAR, busy = 1. CLEAR walks col 0..COLS-1 within row 0..ROWS-1, one tile per cycle, writing {CLR_CHAR, 3'b010, 3'b000}. After the last tile (ROWS-1, COLS-1), the cursor goes to (0,0), the FSM returns to IDLE and busy = 0.
- clr_req and wr_valid are ignored during CLEAR.
- Render path: the tile address comes from {pixel_y[3+CY_W:4], pixel_x[2+CX_W:3]}. Tiles with col ≥ COLS or row ≥ ROWS render 3'b000.
- Pixel colour: fg if the font bit is 1, else bg. For the cursor tile (when visible), fg and bg are swapped.
- rgb = 0 whenever delayed video_on = 0.

## Timing
- Render latency: 2 cycles. Stage 1 registers the RAM read data plus delayed pixel_x/y/video_on; font_addr is driven from these registers. Stage 2 has font_data valid. rgb is combinational from stage 2 and reflects the pixel presented 2 cycles earlier.
- Bit select uses the stage-2 copy of pixel_x[2:0].
- Cursor compare uses the stage-2 tile coordinates against the current cur_x/cur_y.
- A write is visible to the render path on the cycle after acceptance. The cursor updates on the same edge as the write.
- CLEAR lasts exactly ROWS*COLS cycles; wr_ready is 0 throughout.
- Reset values: cur_x = 0, cur_y = 0, busy = 0, font_addr = 0, all pipeline registers 0 (so rgb = 0), blink phase = visible. wr_ready reflects !clr_req after reset.
- A reset during CLEAR aborts the sequence immediately. Partially cleared RAM content remains.

## Configuration
- CURSOR_BLINK_EN defined:
  - A counter 0..BLINK_DIV-1 toggles the cursor phase at its terminal count; reset phase = visible.
  - The cursor is drawn only in the visible phase.
  - Any accepted write restarts the counter and forces the phase to visible.
- CURSOR_BLINK_EN undefined: no counter is built and the cursor is always drawn.

## Test plan
- Reset, then write 'A' (7'h41, fg 3'b010, bg 3'b000) → cur_x = 1; tile (0,0) renders the glyph green-on-black; the cursor tile (0,1) shows 3'b000 fg / 3'b010 bg swap.
- With cur_x = COLS-1, cur_y = ROWS-1, write one character → cursor wraps to (0,0). Writing 7'h0A at (5,3) → cursor (0,4), RAM unchanged.
- Pulse clr_req with wr_valid = 1 on the same cycle → write not accepted; busy high for exactly ROWS*COLS cycles; every tile reads {7'h20, 3'b010, 3'b000}; cursor ends at (0,0).
- Sweep pixel_x with a font ROM model → rgb matches font bit 7..0 left-to-right with 2-cycle lag. video_on = 0 → rgb = 0. With COLS = 40 on a 640-px line, tiles 40..79 render 3'b000.
- Assert reset_n mid-CLEAR → busy = 0 and cursor (0,0) asynchronously; a write is accepted on the first cycle after release.
- With CURSOR_BLINK_EN and BLINK_DIV = 4 → cursor swap toggles every 4 cycles; a write restarts the phase as visible.
